// File: rtl/split_bus_pkg.sv
// Shared types, defaults and the round-robin helper for split_bus_arbiter.
// Optional feature macro used by the arbiter: ARB_TIMEOUT_EN (ownership watchdog).
package split_bus_pkg;

    localparam int DEF_NUM_INIT    = 4;
    localparam int DEF_SPLIT_DEPTH = 4;

    // Upper bound on initiators that rr_pick can scan.
    localparam int MAX_INIT = 32;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        SPLIT_RETURN
    } arb_state_e;

    // First set bit of req strictly after index last, wrapping modulo n.
    // Returns last when req is empty; callers only use the result when req != 0.
    function automatic int rr_pick(input logic [MAX_INIT-1:0] req, input int last, input int n);
        int  pick;
        int  idx;
        logic found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= MAX_INIT; i++) begin
            if (!found && i <= n) begin
                idx = last + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/split_bus_arbiter_if.sv
// Request/grant bundle between the initiators, the split target and the arbiter.
// The arbiter connects through modport master; the bus side through modport slave.
// timeout_err exists only when ARB_TIMEOUT_EN is defined.
interface split_bus_if
    import split_bus_pkg::*;
#(
    parameter int NUM_INIT = DEF_NUM_INIT
) ();

    localparam int IDW = $clog2(NUM_INIT);

    logic [NUM_INIT-1:0] init_req;
    logic                txn_done;
    logic                split_ack;
    logic                split_req;
    logic [NUM_INIT-1:0] init_grant;
    logic [IDW-1:0]      init_owner;
    logic                bus_busy;
    logic                split_grant;
    logic [IDW-1:0]      split_owner;
    logic [NUM_INIT-1:0] split_pending;
    logic                split_overflow;
`ifdef ARB_TIMEOUT_EN
    logic                timeout_err;

    modport master (
        input  init_req, txn_done, split_ack, split_req,
        output init_grant, init_owner, bus_busy, split_grant, split_owner,
               split_pending, split_overflow, timeout_err
    );

    modport slave (
        output init_req, txn_done, split_ack, split_req,
        input  init_grant, init_owner, bus_busy, split_grant, split_owner,
               split_pending, split_overflow, timeout_err
    );
`else
    modport master (
        input  init_req, txn_done, split_ack, split_req,
        output init_grant, init_owner, bus_busy, split_grant, split_owner,
               split_pending, split_overflow
    );

    modport slave (
        output init_req, txn_done, split_ack, split_req,
        input  init_grant, init_owner, bus_busy, split_grant, split_owner,
               split_pending, split_overflow
    );
`endif

endinterface

// File: rtl/split_owner_fifo.sv
// In-order FIFO of parked initiator indices: circular buffer with wrapping
// read/write pointers and an occupancy count. Push when full and pop when
// empty are dropped.
module split_owner_fifo
    import split_bus_pkg::*;
#(
    parameter int DEPTH = DEF_SPLIT_DEPTH,
    parameter int WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              din,
    output logic                          full,
    output logic                          empty,
    output logic [WIDTH-1:0]              head,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy update.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; count/pointers mark which entries are valid.
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/split_bus_arbiter.sv
// Round-robin bus arbiter for NUM_INIT initiators with split-transaction
// support: split-acked owners are parked in an in-order FIFO and the split
// target is handed the bus for each data return. All outputs are registered.
// Optional ownership watchdog: define ARB_TIMEOUT_EN.
module split_bus_arbiter
    import split_bus_pkg::*;
#(
    parameter int NUM_INIT       = DEF_NUM_INIT,
    parameter int SPLIT_DEPTH    = DEF_SPLIT_DEPTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic         clk,
    input logic         rst_n,
    split_bus_if.master bus
);

    localparam int IDW = $clog2(NUM_INIT);
    localparam int CW  = $clog2(SPLIT_DEPTH + 1);

    if (NUM_INIT < 2 || NUM_INIT > MAX_INIT) begin : g_bad_num_init
        $error("split_bus_arbiter: NUM_INIT out of range");
    end
    if (SPLIT_DEPTH < 1) begin : g_bad_split_depth
        $error("split_bus_arbiter: SPLIT_DEPTH must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("split_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_e          state_q, state_d;
    logic [NUM_INIT-1:0] grant_q, grant_d;
    logic [NUM_INIT-1:0] pend_q, pend_d;
    logic [IDW-1:0]      owner_q, owner_d;
    logic [IDW-1:0]      last_q, last_d;
    logic [IDW-1:0]      split_owner_q, split_owner_d;
    logic                split_grant_q, split_grant_d;
    logic                busy_q, busy_d;
    logic                ovf_q, ovf_d;

    logic [NUM_INIT-1:0] eligible;
    logic [IDW-1:0]      winner;
    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [IDW-1:0]      fifo_head;
    logic [CW-1:0]       unused_fifo_count;

`ifdef ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wd_q, wd_d;
    logic           tout_q, tout_d;
    logic           wd_expired;
    assign wd_expired = (wd_q == WDW'(TIMEOUT_CYCLES - 1));
`endif

    // Parked initiators are invisible to arbitration.
    assign eligible = bus.init_req & ~pend_q;
    assign winner   = IDW'(rr_pick(MAX_INIT'(eligible), int'(last_q), NUM_INIT));

    split_owner_fifo #(
        .DEPTH (SPLIT_DEPTH),
        .WIDTH (IDW)
    ) u_owner_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (owner_q),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head),
        .count (unused_fifo_count)
    );

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        pend_d        = pend_q;
        owner_d       = owner_q;
        last_d        = last_q;
        split_owner_d = split_owner_q;
        split_grant_d = split_grant_q;
        ovf_d         = ovf_q;
        fifo_push     = 1'b0;
        fifo_pop      = 1'b0;
`ifdef ARB_TIMEOUT_EN
        tout_d        = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.split_req && !fifo_empty) begin
                    state_d       = SPLIT_RETURN;
                    split_grant_d = 1'b1;
                    split_owner_d = fifo_head;
                end else if (|eligible) begin
                    state_d          = GRANT;
                    owner_d          = winner;
                    grant_d          = '0;
                    grant_d[winner]  = 1'b1;
                end
            end
            GRANT: begin
                if (bus.split_ack) begin
                    // Split ack beats a simultaneous txn_done; the pointer is not advanced.
                    if (!fifo_full) begin
                        fifo_push       = 1'b1;
                        pend_d[owner_q] = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    grant_d = '0;
                    state_d = IDLE;
                end else if (bus.txn_done || !bus.init_req[owner_q]) begin
                    // Completion or abort: this owner goes to the back of the rotation.
                    grant_d = '0;
                    last_d  = owner_q;
                    state_d = IDLE;
`ifdef ARB_TIMEOUT_EN
                end else if (wd_expired) begin
                    grant_d = '0;
                    last_d  = owner_q;
                    tout_d  = 1'b1;
                    state_d = IDLE;
`endif
                end
            end
            SPLIT_RETURN: begin
                if (bus.txn_done) begin
                    fifo_pop          = 1'b1;
                    pend_d[fifo_head] = 1'b0;
                    split_grant_d     = 1'b0;
                    state_d           = IDLE;
                end else if (!bus.split_req) begin
                    // Target withdrew: keep the owner parked for a later return.
                    split_grant_d = 1'b0;
                    state_d       = IDLE;
`ifdef ARB_TIMEOUT_EN
                end else if (wd_expired) begin
                    fifo_pop          = 1'b1;
                    pend_d[fifo_head] = 1'b0;
                    split_grant_d     = 1'b0;
                    tout_d            = 1'b1;
                    state_d           = IDLE;
`endif
                end
            end
            default: begin
                state_d       = IDLE;
                grant_d       = '0;
                split_grant_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
`ifdef ARB_TIMEOUT_EN
        // Counts cycles of continuous ownership; any state change restarts it.
        wd_d = '0;
        if (state_q != IDLE && state_d == state_q) begin
            wd_d = wd_q + 1'b1;
        end
`endif
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            pend_q        <= '0;
            owner_q       <= '0;
            last_q        <= IDW'(NUM_INIT - 1);
            split_owner_q <= '0;
            split_grant_q <= 1'b0;
            busy_q        <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            pend_q        <= pend_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
            split_owner_q <= split_owner_d;
            split_grant_q <= split_grant_d;
            busy_q        <= busy_d;
            ovf_q         <= ovf_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog counter and one-cycle error pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_q   <= '0;
            tout_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            tout_q <= tout_d;
        end
    end

    assign bus.timeout_err = tout_q;
`endif

    assign bus.init_grant     = grant_q;
    assign bus.init_owner     = owner_q;
    assign bus.bus_busy       = busy_q;
    assign bus.split_grant    = split_grant_q;
    assign bus.split_owner    = split_owner_q;
    assign bus.split_pending  = pend_q;
    assign bus.split_overflow = ovf_q;

endmodule

// File: tb/tb_split_bus_arbiter.sv
// Self-checking bench for split_bus_arbiter. Five initiators with a
// four-deep FIFO so that a fifth split ack can reach a full FIFO.
// Every cycle is compared against a queue-based reference model.
module tb_split_bus_arbiter;

    localparam int N  = 5;
    localparam int D  = 4;
    localparam int TO = 8;

    localparam int M_IDLE  = 0;
    localparam int M_GRANT = 1;
    localparam int M_SPLIT = 2;

    logic clk;
    logic rst_n;

    split_bus_if #(.NUM_INIT(N)) bus ();

    split_bus_arbiter #(
        .NUM_INIT       (N),
        .SPLIT_DEPTH    (D),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    int          m_state;
    logic [N-1:0] m_grant;
    int          m_owner;
    int          m_last;
    int          m_so;
    logic        m_sg;
    logic        m_ovf;
    logic        m_tout;
    int          m_age;
    int          park_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] parked();
        logic [N-1:0] v;
        v = '0;
        foreach (park_q[i]) v[park_q[i]] = 1'b1;
        return v;
    endfunction

    function automatic logic timed_out();
`ifdef ARB_TIMEOUT_EN
        return (m_age == TO - 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic release_bus();
        m_grant = '0;
        m_sg    = 1'b0;
        m_state = M_IDLE;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        logic [N-1:0] elig;
        int pick;
        m_tout = 1'b0;
        if (!rst_n) begin
            m_state = M_IDLE;
            m_grant = '0;
            m_owner = 0;
            m_last  = N - 1;
            m_so    = 0;
            m_sg    = 1'b0;
            m_ovf   = 1'b0;
            m_age   = 0;
            park_q.delete();
            return;
        end
        case (m_state)
            M_IDLE: begin
                if (bus.split_req && park_q.size() != 0) begin
                    m_state = M_SPLIT;
                    m_sg    = 1'b1;
                    m_so    = park_q[0];
                    m_age   = 0;
                end else begin
                    elig = bus.init_req & ~parked();
                    pick = -1;
                    for (int k = 1; k <= N; k++) begin
                        if (pick < 0 && elig[(m_last + k) % N]) pick = (m_last + k) % N;
                    end
                    if (pick >= 0) begin
                        m_state = M_GRANT;
                        m_owner = pick;
                        m_grant = '0;
                        m_grant[pick] = 1'b1;
                        m_age   = 0;
                    end
                end
            end
            M_GRANT: begin
                if (bus.split_ack) begin
                    if (park_q.size() < D) park_q.push_back(m_owner);
                    else m_ovf = 1'b1;
                    release_bus();
                end else if (bus.txn_done || !bus.init_req[m_owner]) begin
                    m_last = m_owner;
                    release_bus();
                end else if (timed_out()) begin
                    m_last = m_owner;
                    m_tout = 1'b1;
                    release_bus();
                end else begin
                    m_age++;
                end
            end
            default: begin
                if (bus.txn_done) begin
                    void'(park_q.pop_front());
                    release_bus();
                end else if (!bus.split_req) begin
                    release_bus();
                end else if (timed_out()) begin
                    void'(park_q.pop_front());
                    m_tout = 1'b1;
                    release_bus();
                end else begin
                    m_age++;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check("init_grant", 32'(bus.init_grant), 32'(m_grant));
        check("init_owner", 32'(bus.init_owner), 32'(m_owner));
        check("bus_busy", 32'(bus.bus_busy), 32'(m_state != M_IDLE));
        check("split_grant", 32'(bus.split_grant), 32'(m_sg));
        if (m_sg) check("split_owner", 32'(bus.split_owner), 32'(m_so));
        check("split_pending", 32'(bus.split_pending), 32'(parked()));
        check("split_overflow", 32'(bus.split_overflow), 32'(m_ovf));
`ifdef ARB_TIMEOUT_EN
        check("timeout_err", 32'(bus.timeout_err), 32'(m_tout));
`endif
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.init_req  = '0;
        bus.txn_done  = 1'b0;
        bus.split_ack = 1'b0;
        bus.split_req = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic pulse_done();
        bus.txn_done = 1'b1;
        cycle();
        bus.txn_done = 1'b0;
    endtask

    task automatic pulse_split_ack();
        bus.split_ack = 1'b1;
        cycle();
        bus.split_ack = 1'b0;
    endtask

    task automatic wait_grant(input int idx);
        logic [N-1:0] want;
        int k;
        want = '0;
        want[idx] = 1'b1;
        k = 0;
        while (bus.init_grant !== want && k < 30) begin
            cycle();
            k++;
        end
        check("wait_grant", 32'(bus.init_grant), 32'(want));
    endtask

    task automatic wait_any_grant();
        int k;
        k = 0;
        while (bus.init_grant === '0 && k < 30) begin
            cycle();
            k++;
        end
        check("wait_any_grant", 32'(bus.init_grant !== '0), 32'(1));
    endtask

    task automatic wait_split();
        int k;
        k = 0;
        while (bus.split_grant !== 1'b1 && k < 30) begin
            cycle();
            k++;
        end
        check("wait_split", 32'(bus.split_grant), 32'(1));
    endtask

    initial begin
        int rr_exp[5];
        int park_order[4];

        rr_exp     = '{0, 1, 2, 3, 0};
        park_order = '{1, 3, 0, 2};
        rst_n      = 1'b0;

        // Reset state and a single request/completion.
        do_reset();
        check("reset_grant", 32'(bus.init_grant), 32'(0));
        check("reset_owner", 32'(bus.init_owner), 32'(0));
        bus.init_req = 5'b00001;
        cycle();
        check("first_grant", 32'(bus.init_grant), 32'(5'b00001));
        pulse_done();
        check("grant_dropped", 32'(bus.init_grant), 32'(0));
        bus.init_req = '0;
        cycle();

        // Round-robin rotation with one idle cycle between owners.
        do_reset();
        bus.init_req = 5'b01111;
        for (int i = 0; i < 5; i++) begin
            wait_any_grant();
            check("rr_owner", 32'(bus.init_owner), 32'(rr_exp[i]));
            pulse_done();
            check("rr_idle_gap", 32'(bus.bus_busy), 32'(0));
        end
        bus.init_req = '0;
        cycle();

        // Park initiator 2, ignore its request, then return its data.
        do_reset();
        bus.init_req = 5'b00100;
        wait_grant(2);
        pulse_split_ack();
        check("park_pending", 32'(bus.split_pending), 32'(5'b00100));
        repeat (3) cycle();
        check("parked_ignored", 32'(bus.init_grant), 32'(0));
        bus.init_req  = '0;
        bus.split_req = 1'b1;
        wait_split();
        check("return_owner", 32'(bus.split_owner), 32'(2));
        pulse_done();
        bus.split_req = 1'b0;
        cycle();
        check("return_cleared", 32'(bus.split_pending), 32'(0));

        // In-order returns and overflow on a full FIFO.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.init_req = '0;
            bus.init_req[park_order[i]] = 1'b1;
            wait_grant(park_order[i]);
            pulse_split_ack();
        end
        bus.init_req = 5'b10000;
        wait_grant(4);
        pulse_split_ack();
        check("overflow_set", 32'(bus.split_overflow), 32'(1));
        check("overflow_not_parked", 32'(bus.split_pending), 32'(5'b01111));
        bus.init_req  = '0;
        bus.split_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_split();
            check("fifo_order", 32'(bus.split_owner), 32'(park_order[i]));
            pulse_done();
        end
        bus.split_req = 1'b0;
        cycle();
        check("fifo_drained", 32'(bus.split_pending), 32'(0));

        // Split ack beats txn_done; request drop releases the grant.
        do_reset();
        bus.init_req = 5'b00001;
        wait_grant(0);
        bus.txn_done  = 1'b1;
        bus.split_ack = 1'b1;
        cycle();
        bus.txn_done  = 1'b0;
        bus.split_ack = 1'b0;
        check("ack_beats_done", 32'(bus.split_pending), 32'(5'b00001));
        bus.init_req = 5'b00010;
        wait_grant(1);
        bus.init_req = '0;
        cycle();
        check("abort_release", 32'(bus.init_grant), 32'(0));
        cycle();

`ifdef ARB_TIMEOUT_EN
        // Watchdog: an owner that never finishes is evicted after TO cycles.
        begin
            int k;
            do_reset();
            bus.init_req = 5'b00011;
            wait_grant(0);
            k = 0;
            while (bus.timeout_err !== 1'b1 && k < 30) begin
                cycle();
                k++;
            end
            check("timeout_latency", 32'(k), 32'(TO));
            check("timeout_released", 32'(bus.init_grant), 32'(0));
            cycle();
            cycle();
            check("timeout_next", 32'(bus.init_grant), 32'(5'b00010));
            bus.init_req = '0;
            pulse_done();
        end
`endif

        // Random traffic against the model, including occasional resets.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bus.init_req  = N'($urandom);
            bus.txn_done  = ($urandom_range(3) == 0);
            bus.split_ack = ($urandom_range(5) == 0);
            bus.split_req = ($urandom_range(2) == 0);
            rst_n         = ($urandom_range(149) != 0);
            cycle();
        end
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
